// File: rtl/exconv_fp32pck16_seq.sv
// exconv_fp32pck16_seq: sequenced FP32->FP16 vector pack unit.
// A 2- or 4-element FP32 request is latched, and LANES truncating scalar
// converters are stepped over it. The packed 64-bit FP16 result is then
// returned over a valid/ready handshake. One request is in flight at a time.
module exconv_fp32pck16_seq #(
    parameter int LANES = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         reqValid,
    output logic         reqReady,
    input  logic [127:0] reqData,
    input  logic         reqWide,
    output logic         rspValid,
    input  logic         rspReady,
    output logic [63:0]  rspData,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [1:0]     r_idx;
    logic [127:0]   r_req_data;
    logic           r_req_wide;
    logic [63:0]    r_rsp_data;
    logic           r_rsp_valid;
    logic           r_req_ready;
    logic           r_busy;

    logic [63:0]    w_conv_data;
    logic           w_last;

    // Truncating scalar conversion. Exponents that are out of range saturate
    // to all-ones or all-zeros, and the mantissa is always passed through
    // unchanged, even when the exponent saturates.
    function automatic logic [15:0] fp32_to_fp16(input logic [31:0] v);
        logic [4:0] exp5;
        if ((v[30:26] == 5'h0F) || (v[30:26] == 5'h10)) begin
            exp5 = {v[30], v[26:23]};
        end else if (v[30]) begin
            exp5 = 5'h1F;
        end else begin
            exp5 = 5'h00;
        end
        return {v[31], exp5, v[22:13]};
    endfunction

    // Lanes index..index+LANES-1 get fresh results; every other lane keeps its value.
    always_comb begin
        w_conv_data = r_rsp_data;
        for (int e = 0; e < 4; e++) begin
            if ((e >= int'(r_idx)) && (e < (int'(r_idx) + LANES))) begin
                w_conv_data[16*e +: 16] = fp32_to_fp16(r_req_data[32*e +: 32]);
            end else begin
                w_conv_data[16*e +: 16] = r_rsp_data[16*e +: 16];
            end
        end
    end

    // The current step is the final one when it covers the last element of the request.
    always_comb begin
        if (({1'b0, r_idx} + 3'(LANES)) == (r_req_wide ? 3'd4 : 3'd2)) begin
            w_last = 1'b1;
        end else begin
            w_last = 1'b0;
        end
    end

    // Control FSM: it owns the request latch, the index and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_idx       <= 2'd0;
            r_req_data  <= 128'd0;
            r_req_wide  <= 1'b0;
            r_rsp_data  <= 64'd0;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (reqValid && r_req_ready) begin
                        r_req_data  <= reqData;
                        r_req_wide  <= reqWide;
                        r_rsp_data  <= 64'd0;
                        r_idx       <= 2'd0;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    r_rsp_data <= w_conv_data;
                    r_idx      <= r_idx + 2'(LANES);
                    if (w_last) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rspReady) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_idx       <= 2'd0;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign reqReady = r_req_ready;
    assign rspValid = r_rsp_valid;
    assign rspData  = r_rsp_data;
    assign busy     = r_busy;

endmodule

// File: tb/tb_exconv_fp32pck16_seq.sv
// Bench for exconv_fp32pck16_seq: one instance with LANES=1 (index 0) and one
// with LANES=2 (index 1). Results come from an arithmetic reference model.
module tb_exconv_fp32pck16_seq;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         req_valid [2];
    logic         req_ready [2];
    logic [127:0] req_data  [2];
    logic         req_wide  [2];
    logic         rsp_valid [2];
    logic         rsp_ready [2];
    logic [63:0]  rsp_data  [2];
    logic         busy      [2];

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    exconv_fp32pck16_seq #(.LANES(1)) dut1 (
        .clock(clock), .reset(reset),
        .reqValid(req_valid[0]), .reqReady(req_ready[0]),
        .reqData(req_data[0]), .reqWide(req_wide[0]),
        .rspValid(rsp_valid[0]), .rspReady(rsp_ready[0]),
        .rspData(rsp_data[0]), .busy(busy[0])
    );

    exconv_fp32pck16_seq #(.LANES(2)) dut2 (
        .clock(clock), .reset(reset),
        .reqValid(req_valid[1]), .reqReady(req_ready[1]),
        .reqData(req_data[1]), .reqWide(req_wide[1]),
        .rspValid(rsp_valid[1]), .rspReady(rsp_ready[1]),
        .rspData(rsp_data[1]), .busy(busy[1])
    );

    // Reference scalar: biased FP32 exponents 120..135 map to (e - 112).
    // Larger exponents saturate to 31 and smaller ones to 0. The mantissa is truncated.
    function automatic logic [15:0] ref_elem(input logic [31:0] v);
        int e;
        int x;
        int m;
        e = int'(v[30:23]);
        if (e >= 120 && e <= 135) x = e - 112;
        else if (e >= 128) x = 31;
        else x = 0;
        m = int'(v[22:0]) / 8192;
        return {v[31], 5'(x), 10'(m)};
    endfunction

    function automatic logic [63:0] ref_vec(input logic [127:0] d, input logic w);
        logic [63:0] r;
        int n;
        r = 64'd0;
        n = w ? 4 : 2;
        for (int i = 0; i < n; i++) r[16*i +: 16] = ref_elem(d[32*i +: 32]);
        return r;
    endfunction

    function automatic int lanes_of(input int u);
        return u + 1;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One complete transaction with rspReady held high. It returns the latency in edges
    // after the accept, the number of busy cycles, the result, a post-handshake idle flag, and a timeout flag.
    task automatic do_txn(input int u, input logic [127:0] d, input logic w,
                          output int lat, output int bcyc, output logic [63:0] res,
                          output logic idle_after, output logic to);
        int guard;
        to = 1'b0; lat = 0; bcyc = 0; res = 64'd0; idle_after = 1'b0;
        rsp_ready[u] = 1'b1;
        guard = 0;
        while (req_ready[u] !== 1'b1 && guard < 20) begin
            @(posedge clock); @(negedge clock); guard++;
        end
        if (guard >= 20) begin to = 1'b1; return; end
        req_valid[u] = 1'b1; req_data[u] = d; req_wide[u] = w;
        @(posedge clock); @(negedge clock);
        req_valid[u] = 1'b0; req_data[u] = rand128(); req_wide[u] = 1'($urandom);
        while (1'b1) begin
            if (busy[u] === 1'b1) bcyc++;
            if (rsp_valid[u] === 1'b1) break;
            if (lat >= 20) begin to = 1'b1; return; end
            @(posedge clock); @(negedge clock); lat++;
        end
        res = rsp_data[u];
        @(posedge clock); @(negedge clock);
        idle_after = (busy[u] === 1'b0) && (rsp_valid[u] === 1'b0) && (req_ready[u] === 1'b1);
    endtask

    task automatic test_reset();
        req_valid[0] = 1'b1; req_valid[1] = 1'b1;
        req_data[0] = rand128(); req_data[1] = rand128();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int u = 0; u < 2; u++) begin
            total++;
            if (busy[u] !== 1'b0 || rsp_valid[u] !== 1'b0 || rsp_data[u] !== 64'd0 || req_ready[u] !== 1'b1) begin
                bad++;
                $display("FAIL reset_state u=%0d: busy=%b rspValid=%b rspData=%h reqReady=%b, required 0/0/0/1",
                         u, busy[u], rsp_valid[u], rsp_data[u], req_ready[u]);
            end
        end
        req_valid[0] = 1'b0; req_valid[1] = 1'b0;
        reset = 1'b0;
        @(posedge clock); @(negedge clock);
        for (int u = 0; u < 2; u++) begin
            total++;
            if (busy[u] !== 1'b0) begin
                bad++;
                $display("FAIL reset_no_accept u=%0d: busy=%b, required 0", u, busy[u]);
            end
        end
    endtask

    task automatic test_directed();
        int lat; int bc; logic [63:0] res; logic idl; logic to;
        logic [127:0] wide_vec;
        // narrow in-range, LANES=1
        do_txn(0, {64'd0, 32'hC0000000, 32'h3F800000}, 1'b0, lat, bc, res, idl, to);
        total++;
        if (to || res !== 64'h00000000C0003C00 || lat != 2) begin
            bad++;
            $display("FAIL narrow_l1: data=%h lat=%0d to=%b, required 00000000c0003c00 lat=2", res, lat, to);
        end
        // saturation
        do_txn(0, {rand128() & {64'hFFFFFFFFFFFFFFFF, 64'd0} | {64'd0, 32'h2EDBE6FF, 32'h47800000}},
               1'b0, lat, bc, res, idl, to);
        total++;
        if (to || res !== 64'h0000000002DF7C00) begin
            bad++;
            $display("FAIL saturation: data=%h, required 0000000002df7c00", res);
        end
        wide_vec = {32'hC0000000, 32'h47800000, 32'h3F800000, 32'h00000000};
        for (int u = 0; u < 2; u++) begin
            do_txn(u, wide_vec, 1'b1, lat, bc, res, idl, to);
            total++;
            if (to || res !== 64'hC0007C003C000000) begin
                bad++;
                $display("FAIL wide_data u=%0d: data=%h, required c0007c003c000000", u, res);
            end
            total++;
            if (lat != 4 / lanes_of(u) || bc != 4 / lanes_of(u) + 1 || !idl) begin
                bad++;
                $display("FAIL wide_timing u=%0d: lat=%0d busy=%0d idle=%b, required lat=%0d busy=%0d idle=1",
                         u, lat, bc, idl, 4 / lanes_of(u), 4 / lanes_of(u) + 1);
            end
        end
        // narrow, LANES=2
        do_txn(1, {64'd0, 32'hC0000000, 32'h3F800000}, 1'b0, lat, bc, res, idl, to);
        total++;
        if (to || res !== 64'h00000000C0003C00 || lat != 1) begin
            bad++;
            $display("FAIL narrow_l2: data=%h lat=%0d, required 00000000c0003c00 lat=1", res, lat);
        end
    endtask

    task automatic test_random();
        int lat; int bc; logic [63:0] res; logic idl; logic to;
        logic [127:0] d; logic w; logic [63:0] exp_r; int exp_lat;
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < 25; k++) begin
                d = rand128();
                // Exponents are biased toward the in-range window so that every rule is exercised.
                for (int i = 0; i < 4; i++) begin
                    if ($urandom_range(0, 1) == 0) d[32*i+23 +: 8] = 8'(118 + $urandom_range(0, 19));
                end
                w = 1'($urandom);
                exp_r = ref_vec(d, w);
                exp_lat = (w ? 4 : 2) / lanes_of(u);
                do_txn(u, d, w, lat, bc, res, idl, to);
                total++;
                if (to || res !== exp_r || lat != exp_lat || !idl) begin
                    bad++;
                    $display("FAIL random u=%0d k=%0d: data=%h lat=%0d idle=%b, required %h lat=%0d idle=1",
                             u, k, res, lat, idl, exp_r, exp_lat);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] da; logic [127:0] db;
        logic [63:0] ea; logic [63:0] eb;
        int guard; int lat;
        da = rand128(); db = rand128();
        ea = ref_vec(da, 1'b0); eb = ref_vec(db, 1'b1);
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1; req_data[0] = da; req_wide[0] = 1'b0;
        @(posedge clock); @(negedge clock);
        req_valid[0] = 1'b0;
        guard = 0;
        while (rsp_valid[0] !== 1'b1 && guard < 20) begin
            @(posedge clock); @(negedge clock); guard++;
        end
        total++;
        if (guard >= 20) begin
            bad++;
            $display("FAIL bp_wait: rspValid never rose");
        end
        req_valid[0] = 1'b1; req_data[0] = db; req_wide[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); @(negedge clock);
            total++;
            if (rsp_data[0] !== ea || req_ready[0] !== 1'b0 || rsp_valid[0] !== 1'b1 || busy[0] !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold c=%0d: data=%h reqReady=%b rspValid=%b busy=%b, required %h 0 1 1",
                         c, rsp_data[0], req_ready[0], rsp_valid[0], busy[0], ea);
            end
        end
        rsp_ready[0] = 1'b1;
        @(posedge clock); @(negedge clock);
        total++;
        if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 || busy[0] !== 1'b0 || rsp_data[0] !== ea) begin
            bad++;
            $display("FAIL bp_idle: reqReady=%b rspValid=%b busy=%b data=%h, required 1 0 0 %h",
                     req_ready[0], rsp_valid[0], busy[0], rsp_data[0], ea);
        end
        @(posedge clock); @(negedge clock);
        req_valid[0] = 1'b0;
        total++;
        if (busy[0] !== 1'b1 || req_ready[0] !== 1'b0 || rsp_data[0] !== 64'd0) begin
            bad++;
            $display("FAIL bp_accept: busy=%b reqReady=%b data=%h, required 1 0 0", busy[0], req_ready[0], rsp_data[0]);
        end
        lat = 0;
        while (rsp_valid[0] !== 1'b1 && lat < 20) begin
            @(posedge clock); @(negedge clock); lat++;
        end
        total++;
        if (rsp_data[0] !== eb || lat != 4) begin
            bad++;
            $display("FAIL bp_second: data=%h lat=%0d, required %h lat=4", rsp_data[0], lat, eb);
        end
        @(posedge clock); @(negedge clock);
    endtask

    task automatic test_reset_mid_conv();
        int seen;
        rsp_ready[0] = 1'b1;
        req_valid[0] = 1'b1; req_data[0] = rand128(); req_wide[0] = 1'b1;
        @(posedge clock); @(negedge clock);
        req_valid[0] = 1'b0;
        @(posedge clock); @(negedge clock);
        reset = 1'b1;
        @(posedge clock); @(negedge clock);
        reset = 1'b0;
        total++;
        if (rsp_valid[0] !== 1'b0 || rsp_data[0] !== 64'd0 || busy[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset: rspValid=%b data=%h busy=%b reqReady=%b, required 0 0 0 1",
                     rsp_valid[0], rsp_data[0], busy[0], req_ready[0]);
        end
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clock); @(negedge clock);
            if (rsp_valid[0] === 1'b1 || busy[0] === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL mid_reset_no_rsp: activity cycles=%0d, required 0", seen);
        end
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0; req_data[u] = 128'd0; req_wide[u] = 1'b0; rsp_ready[u] = 1'b1;
        end
        @(negedge clock);
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_conv();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exconv_fp32pck16_seq.md
# exconv_fp32pck16_seq

Sequenced vector FP32→FP16 pack unit for the execute-stage conversion path. Accepts a 2- or 4-element packed FP32 vector over a valid/ready handshake, pushes the elements through `LANES` scalar truncating FP32→FP16 converters over several cycles, and returns the packed 64-bit FP16 result over a second valid/ready handshake. It keeps converter area small for wide pack ops; one request is in flight at a time.

## Interface

- `LANES`, default 1, is the number of scalar converter instances. Legal values are 1 or 2; each CONV cycle converts `LANES` elements.
- `clock`  in  1  is the sole clock; all state is updated on the rising edge.
- `reset`  in  1  is a synchronous, active-high reset.
- `reqValid`  in  1  means a request is present.
- `reqReady`  out  1  means the unit can accept a request; it is 1 only in IDLE.
- `reqData`  in  128  carries the elements: element i = `reqData[32i+31:32i]`.
- `reqWide`  in  1  selects the element count: 0 = 2 elements (i = 0..1, `reqData[127:64]` ignored); 1 = 4 elements.
- `rspValid`  out  1  means the result is valid.
- `rspReady`  in  1  means the consumer accepts the result.
- `rspData`  out  64  carries the results: element i result = `rspData[16i+15:16i]`. Unused lanes are 0.
- `busy`  out  1  is high in CONV or DONE.

## Operation

- **Scalar rule, per element `v`**
  - sign = `v[31]`.
  - If `v[30:26]` is 0x0F or 0x10, exp5 = {`v[30]`, `v[26:23]`}. Otherwise exp5 = 0x1F when `v[30]` = 1, and 0x00 when `v[30]` = 0.
  - mant10 = `v[22:13]`, truncated with no rounding.
  - Result = {sign, exp5, mant10}. Mantissa bits pass through unchanged even when the exponent saturates.
- **States:** IDLE, CONV, DONE. The element index counter is 2 bits.
- **IDLE**
  - `reqReady` = 1.
  - On `reqValid & reqReady`: latch `reqData` and `reqWide`, clear `rspData` to 0, set index = 0, and go to CONV.
- **CONV**
  - Each edge converts elements index .. index+LANES−1 from the latched copy, writes their lanes of `rspData`, and advances index by LANES.
  - The step count is N = (reqWide ? 4 : 2) / LANES.
  - After the N-th CONV edge, go to DONE and set `rspValid` = 1.
- **DONE**
  - `rspValid` = 1, and `rspData` holds stable.
  - On `rspValid & rspReady`: clear `rspValid` and go to IDLE.
  - `rspData` keeps its last value until the next accept clears it.
- Inputs on `reqData` and `reqWide` are don't-care outside the accept cycle, because the latched copy is used.
- `reqValid` while not in IDLE is ignored; the requester must hold it.

## Timing

- Reset values:
  - state = IDLE
  - `reqReady` = 1 after the reset edge
  - `rspValid` = 0
  - `rspData` = 0
  - `busy` = 0
  - index = 0
  - latched request = 0
- `reset` takes priority over everything. A request presented in a cycle with `reset` high is not accepted.
- Reset during CONV or DONE aborts the operation. No response is produced, and `rspValid` is 0 after the edge.
- Latency: if the accept happens at edge E, `rspValid` is first high after edge E+N.
  - LANES=1: N = 4 for wide, 2 for narrow.
  - LANES=2: N = 2 for wide, 1 for narrow.
- Throughput: at best one request per N+2 cycles. There is a one-cycle IDLE bubble after the response handshake, because `reqReady` is a function of registered state only.
- `rspReady` may be held high indefinitely. With `rspReady` already high, DONE lasts exactly 1 cycle.
- No combinational path exists from `rspReady` or `reqValid` to any output.

## Test plan

- **Scalar in-range, narrow, LANES=1.** `reqData[63:0]` = {0xC0000000, 0x3F800000}, `reqWide` = 0.
  - `rspData` = 0x00000000C0003C00.
  - `rspValid` is first high 2 edges after accept.
- **Saturation.** Element 0 = 0x47800000 gives 0x7C00. Element 1 = 0x2EDBE6FF gives 0x02DF (exp forced to 0, mantissa passed through).
  - `rspData[31:0]` = 0x02DF7C00.
- **Wide, LANES=1.** `reqData` = {0xC0000000, 0x47800000, 0x3F800000, 0x00000000}.
  - `rspData` = 0xC0007C003C000000.
  - `rspValid` rises 4 edges after accept. `busy` is high for 5 cycles with immediate `rspReady`.
- **Same vector with LANES=2.**
  - Same `rspData`.
  - `rspValid` rises 2 edges after accept.
- **Backpressure.** Hold `rspReady` = 0 for 3 cycles in DONE, with `reqValid` = 1 and new data.
  - `rspData` is stable.
  - `reqReady` = 0, and no new accept occurs.
  - After the handshake, the next edge is IDLE and the new request is accepted one cycle later.
- **Reset mid-CONV.** Assert `reset` at the 2nd CONV edge of a wide request.
  - After that edge: `rspValid` = 0, `rspData` = 0, `busy` = 0, `reqReady` = 1.
  - No response ever appears for the aborted request.
